// File: rtl/reset_pkg.sv
// Shared widths, depth and sweep-controller state encoding for the
// clearable register file.
package reset_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  // Address of the final entry touched by a clear sweep.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reset_if.sv
// Register-file access bundle: sweep trigger, write port and
// combinational read port.
interface reset_if;
  import reset_pkg::*;

  logic              go;
  logic              enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output go,
    output enable,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  go,
    input  enable,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/reset_clear_sequencer.sv
// Sweep controller: on go in IDLE, walks cnt over every address,
// requesting one register clear per clock, then returns to IDLE.
module reset_clear_sequencer
  import reset_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_en     = 1'b0;
    clr_addr   = cnt_reg;
    busy       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        // go is ignored here, so the sweep always lasts exactly DEPTH edges.
        busy   = 1'b1;
        clr_en = 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/reset.sv
// 16 x 32 register file with one write port, a combinational read port,
// an asynchronous reset and a one-entry-per-clock software clear sweep.
module reset
  import reset_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  reset_if.slave bus
);

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;
  logic              wr_en;
  logic [DEPTH-1:0]  clr_hit;
  logic [DEPTH-1:0]  wr_hit;
  logic [DATA_W-1:0] mem_reg [DEPTH];

  reset_clear_sequencer u_clear_sequencer (
    .clk      (clk),
    .rst      (rst),
    .go       (bus.go),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // Writes are dropped for the whole sweep, including its final edge.
  assign wr_en = bus.enable && !busy;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign clr_hit[gi] = clr_en && (clr_addr == ADDR_W'(gi));
      assign wr_hit[gi]  = wr_en && (bus.wr_addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_hit[i]) begin
          mem_reg[i] <= '0;
        end else if (wr_hit[i]) begin
          mem_reg[i] <= bus.wr_data;
        end
      end
    end
  end

  assign bus.rd_data = mem_reg[bus.rd_addr];

endmodule

// File: tb/tb_reset.sv
// Directed bench for the clearable register file: reset, write/read,
// sweep timing, dropped writes, go re-assertion and reset abort.
`timescale 1ns/1ps
module tb_reset;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reset_if bus ();

  reset dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #20 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bus.rd_addr = a;
    #1;
    checks++;
    assert (bus.rd_data === exp)
      else begin
        errors++;
        $error("FAIL %s addr=%0d got=%h exp=%h", tag, a, bus.rd_data, exp);
      end
    $display("check %s addr=%0d rd_data=%h exp=%h", tag, a, bus.rd_data, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.enable  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick(1);
    bus.enable  = 1'b0;
  endtask

  initial begin
    bus.go      = 1'b0;
    bus.enable  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;

    // Power-on reset
    #1 rst = 1'b1;
    chk(4'd0, 32'd0, "reset_state");
    tick(2);
    rst = 1'b0;
    tick(1);

    // Consecutive writes, then read back including an unwritten address
    wr(4'd1, 32'd15);
    wr(4'd5, 32'd20);
    wr(4'd15, 32'd25);
    chk(4'd1, 32'd15, "wr_rd_1");
    chk(4'd4, 32'd0, "wr_rd_4");
    chk(4'd5, 32'd20, "wr_rd_5");
    chk(4'd15, 32'd25, "wr_rd_15");
    wr(4'd0, 32'hDEAD_BEEF);
    chk(4'd0, 32'hDEAD_BEEF, "wr_rd_0");

    // Asynchronous reset between edges clears everything at once
    #5 rst = 1'b1;
    #1;
    for (int a = 0; a < 16; a++) begin
      chk(4'(a), 32'd0, "async_rst");
    end
    rst = 1'b0;
    tick(1);

    // Clear sweep with a dropped write and a re-asserted go
    wr(4'd1, 32'd15);
    wr(4'd5, 32'd20);
    wr(4'd15, 32'd25);
    wr(4'd3, 32'h3C);
    bus.go = 1'b1;
    tick(1);                             // E0
    bus.go = 1'b0;
    chk(4'd1, 32'd15, "sweep_e0_m1");
    tick(1);                             // E0+1
    chk(4'd1, 32'd15, "sweep_e1_m1");
    chk(4'd0, 32'd0, "sweep_e1_m0");
    tick(1);                             // E0+2
    chk(4'd1, 32'd0, "sweep_e2_m1");
    tick(2);                             // E0+4
    chk(4'd3, 32'd0, "sweep_e4_m3");
    wr(4'd3, 32'hA5);                    // E0+5, dropped
    chk(4'd3, 32'd0, "wr_drop_e5");
    tick(2);                             // E0+7
    bus.go = 1'b1;
    tick(1);                             // E0+8, ignored
    bus.go = 1'b0;
    tick(7);                             // E0+15
    chk(4'd15, 32'd25, "sweep_e15_m15");
    wr(4'd4, 32'h44);                    // E0+16, dropped on exit edge
    chk(4'd15, 32'd0, "sweep_e16_m15");
    chk(4'd4, 32'd0, "wr_drop_e16");
    chk(4'd5, 32'd0, "sweep_done_m5");
    chk(4'd3, 32'd0, "sweep_done_m3");
    wr(4'd3, 32'h33);                    // E0+17, accepted
    chk(4'd3, 32'h33, "wr_e17");

    // Reset aborts a running sweep
    wr(4'd10, 32'h10);
    bus.go = 1'b1;
    tick(1);                             // E0
    bus.go = 1'b0;
    tick(7);                             // E0+7
    chk(4'd10, 32'h10, "abort_pre_m10");
    #5 rst = 1'b1;
    #1;
    chk(4'd10, 32'd0, "abort_m10");
    chk(4'd3, 32'd0, "abort_m3");
    rst = 1'b0;
    tick(1);
    wr(4'd2, 32'd7);
    chk(4'd2, 32'd7, "abort_idle_wr");

    // go and enable on the same edge: write lands, then the sweep clears it
    bus.go      = 1'b1;
    bus.enable  = 1'b1;
    bus.wr_addr = 4'd8;
    bus.wr_data = 32'h88;
    tick(1);                             // E0
    bus.go      = 1'b0;
    bus.enable  = 1'b0;
    chk(4'd8, 32'h88, "go_wr_e0");
    tick(8);                             // E0+8
    chk(4'd8, 32'h88, "go_wr_e8");
    tick(1);                             // E0+9
    chk(4'd8, 32'd0, "go_wr_e9");
    tick(7);                             // E0+16
    wr(4'd9, 32'h99);                    // E0+17
    chk(4'd9, 32'h99, "go_wr_e17");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
